// File: rtl/usb4_lane_block_encoder.sv
// Multi-lane USB4 transmit encoder: packs per-lane bytes into 132b (Gen3) or 66b (Gen2)
// blocks with sync headers, or forwards single bytes (Gen4), behind a one-word output buffer.
module usb4_lane_block_encoder #(
    parameter int LANES = 2,
    parameter int OUT_W = 132
) (
    input  logic                   enc_clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [1:0]             gen_speed,
    input  logic [3:0]             d_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*8-1:0]     lane_tx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] lane_tx_enc,
    output logic                   new_sym,
    output logic                   speed_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             r_gen;
    logic [3:0]             r_cnt;
    logic                   r_type;
    logic [LANES*128-1:0]   r_asm;
    logic [LANES*OUT_W-1:0] r_out;
    logic                   r_out_valid;
    logic                   r_new_sym;
    logic                   r_speed_err;

    logic                   w_gen_chg;
    logic [4:0]             w_n;
    logic [3:0]             w_cnt_eff;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_type;
    logic                   w_complete;
    logic                   w_out_free;
    logic                   w_load;
    logic [LANES*128-1:0]   w_asm;
    logic [LANES*OUT_W-1:0] w_word;

    function automatic logic [131:0] f_word(input logic [1:0] gen, input logic is_tp,
                                            input logic [127:0] blk);
        logic [131:0] w;
        w = 132'd0;
        case (gen)
            2'd1:    w = {(is_tp ? 4'b0101 : 4'b1010), blk};
            2'd2:    w = {66'd0, (is_tp ? 2'b01 : 2'b10), blk[63:0]};
            2'd0:    w = {124'd0, blk[7:0]};
            default: w = 132'd0;
        endcase
        return w;
    endfunction

    // HOLD keeps in_ready low so a completed block is never overwritten.
    assign in_ready    = rst && enable && (gen_speed != 2'd3) && (r_state != S_HOLD);
    assign out_valid   = r_out_valid;
    assign lane_tx_enc = r_out;
    assign new_sym     = r_new_sym;
    assign speed_err   = r_speed_err;

    // Next-byte position, block completion and the candidate output word.
    always_comb begin
        w_gen_chg = (gen_speed != r_gen);
        case (gen_speed)
            2'd1:    w_n = 5'd16;
            2'd2:    w_n = 5'd8;
            default: w_n = 5'd1;
        endcase
        w_cnt_eff  = w_gen_chg ? 4'd0 : r_cnt;
        w_accept   = in_valid && in_ready;
        w_last     = w_accept && ({1'b0, w_cnt_eff} == (w_n - 5'd1));
        w_type     = (w_accept && (w_cnt_eff == 4'd0)) ? (d_sel == 4'd8) : r_type;
        w_complete = w_last || ((r_state == S_HOLD) && !w_gen_chg);
        w_out_free = !r_out_valid || out_ready || w_gen_chg;
        w_load     = w_complete && w_out_free;
        w_asm      = w_gen_chg ? {(LANES*128){1'b0}} : r_asm;
        w_word     = {(LANES*OUT_W){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < 16; i++) begin
                w_asm[k*128+8*i +: 8] = (w_accept && (w_cnt_eff == i[3:0])) ?
                                        lane_tx[8*k +: 8] : w_asm[k*128+8*i +: 8];
            end
            w_word[k*OUT_W +: OUT_W] = f_word(gen_speed, w_type, w_asm[k*128 +: 128]);
        end
    end

    // Block assembly, mode tracking and output buffer.
    always_ff @(posedge enc_clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_gen       <= 2'd0;
            r_cnt       <= 4'd0;
            r_type      <= 1'b0;
            r_asm       <= {(LANES*128){1'b0}};
            r_out       <= {(LANES*OUT_W){1'b0}};
            r_out_valid <= 1'b0;
            r_new_sym   <= 1'b0;
            r_speed_err <= 1'b0;
        end else if (!enable || (gen_speed == 2'd3)) begin
            r_state     <= S_IDLE;
            r_gen       <= gen_speed;
            r_cnt       <= 4'd0;
            r_type      <= 1'b0;
            r_asm       <= {(LANES*128){1'b0}};
            r_out       <= {(LANES*OUT_W){1'b0}};
            r_out_valid <= 1'b0;
            r_new_sym   <= 1'b0;
            r_speed_err <= r_speed_err || (enable && (gen_speed == 2'd3));
        end else begin
            r_gen       <= gen_speed;
            r_asm       <= w_asm;
            r_type      <= w_type;
            r_speed_err <= r_speed_err;
            if (w_accept) begin
                r_cnt <= w_last ? 4'd0 : (w_cnt_eff + 4'd1);
            end else begin
                r_cnt <= w_cnt_eff;
            end
            r_state <= (w_complete && !w_load) ? S_HOLD : S_FILL;
            if (w_load) begin
                r_out       <= w_word;
                r_out_valid <= 1'b1;
                r_new_sym   <= 1'b1;
            end else if (w_gen_chg) begin
                r_out       <= {(LANES*OUT_W){1'b0}};
                r_out_valid <= 1'b0;
                r_new_sym   <= 1'b0;
            end else begin
                r_out       <= r_out;
                r_out_valid <= r_out_valid && !out_ready;
                r_new_sym   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb4_lane_block_encoder.sv
// Directed bench for usb4_lane_block_encoder (LANES=2) with hand-built expected words.
module tb_usb4_lane_block_encoder;

    logic         enc_clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   gen_speed;
    logic [3:0]   d_sel;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  lane_tx;
    logic         out_valid;
    logic         out_ready;
    logic [263:0] lane_tx_enc;
    logic         new_sym;
    logic         speed_err;

    int checks = 0;
    int errors = 0;
    int b;
    logic acc;

    usb4_lane_block_encoder #(.LANES(2), .OUT_W(132)) dut (
        .enc_clk(enc_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed),
        .d_sel(d_sel), .in_valid(in_valid), .in_ready(in_ready), .lane_tx(lane_tx),
        .out_valid(out_valid), .out_ready(out_ready), .lane_tx_enc(lane_tx_enc),
        .new_sym(new_sym), .speed_err(speed_err)
    );

    always #5 enc_clk = ~enc_clk;

    task automatic tick();
        @(posedge enc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [3:0] ds);
        lane_tx  = {b1, b0};
        d_sel    = ds;
        in_valid = 1'b1;
        tick();
    endtask

    function automatic logic [131:0] w3(input logic [7:0] base, input logic tp);
        logic [131:0] w;
        w = 132'd0;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = base + i[7:0];
        w[131:128] = tp ? 4'b0101 : 4'b1010;
        return w;
    endfunction

    function automatic logic [131:0] w2(input logic [7:0] base, input logic tp);
        logic [131:0] w;
        w = 132'd0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = base + i[7:0];
        w[65:64] = tp ? 2'b01 : 2'b10;
        return w;
    endfunction

    function automatic logic [131:0] w4(input logic [7:0] v);
        return {124'd0, v};
    endfunction

    initial begin
        rst = 1'b0; enable = 1'b1; gen_speed = 2'd1; d_sel = 4'd0;
        in_valid = 1'b0; lane_tx = 16'd0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", {263'd0, in_ready}, 264'd0);
        chk("rst_out_valid", {263'd0, out_valid}, 264'd0);
        chk("rst_enc", lane_tx_enc, 264'd0);
        chk("rst_new_sym", {263'd0, new_sym}, 264'd0);
        chk("rst_speed_err", {263'd0, speed_err}, 264'd0);

        // Gen3 transport block
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("g3_not_early", {263'd0, out_valid}, 264'd0);
            send(i[7:0], 8'h10 + i[7:0], (i == 0) ? 4'd8 : 4'd3);
        end
        in_valid = 1'b0;
        chk("g3_valid", {263'd0, out_valid}, 264'd1);
        chk("g3_new_sym", {263'd0, new_sym}, 264'd1);
        chk("g3_word", lane_tx_enc, {w3(8'h10, 1'b1), w3(8'h00, 1'b1)});
        tick();
        chk("g3_consumed", {263'd0, out_valid}, 264'd0);
        chk("g3_sym_pulse", {263'd0, new_sym}, 264'd0);

        // Gen2 with type latched on byte 0
        gen_speed = 2'd2;
        tick();
        for (int i = 0; i < 8; i++) send(8'hA0 + i[7:0], 8'hB0 + i[7:0], (i < 3) ? 4'd2 : 4'd8);
        in_valid = 1'b0;
        chk("g2_valid", {263'd0, out_valid}, 264'd1);
        chk("g2_word", lane_tx_enc, {w2(8'hB0, 1'b0), w2(8'hA0, 1'b0)});

        // Gen3 backpressure: second block held in assembly
        gen_speed = 2'd1; out_ready = 1'b0;
        tick();
        chk("bp_cleared", {263'd0, out_valid}, 264'd0);
        b = 0;
        for (int c = 0; c < 40; c++) begin
            lane_tx  = {8'h80 + b[7:0], b[7:0]};
            d_sel    = 4'd8;
            in_valid = 1'b1;
            #1;
            acc = in_ready;
            tick();
            if (acc) b++;
        end
        chk("bp_count", b, 264'd32);
        chk("bp_in_ready", {263'd0, in_ready}, 264'd0);
        chk("bp_valid", {263'd0, out_valid}, 264'd1);
        chk("bp_blk1", lane_tx_enc, {w3(8'h80, 1'b1), w3(8'h00, 1'b1)});
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        chk("bp_blk2", lane_tx_enc, {w3(8'h90, 1'b1), w3(8'h10, 1'b1)});
        chk("bp_blk2_sym", {263'd0, new_sym}, 264'd1);
        chk("bp_blk2_valid", {263'd0, out_valid}, 264'd1);
        chk("bp_ready_back", {263'd0, in_ready}, 264'd1);

        // Gen2 partial block, then switch to Gen3
        gen_speed = 2'd2;
        tick();
        for (int i = 0; i < 5; i++) send(i[7:0], i[7:0], 4'd8);
        in_valid = 1'b0; gen_speed = 2'd1;
        tick();
        chk("sw_cleared", {263'd0, out_valid}, 264'd0);
        for (int i = 0; i < 15; i++) send(8'h40 + i[7:0], 8'h60 + i[7:0], 4'd0);
        chk("sw_not_early", {263'd0, out_valid}, 264'd0);
        send(8'h4F, 8'h6F, 4'd0);
        in_valid = 1'b0;
        chk("sw_valid", {263'd0, out_valid}, 264'd1);
        chk("sw_word", lane_tx_enc, {w3(8'h60, 1'b0), w3(8'h40, 1'b0)});

        // Gen4 byte mode
        gen_speed = 2'd0;
        tick();
        for (int c = 0; c < 4; c++) begin
            send((c % 2 == 0) ? 8'hA5 : 8'h5A, (c % 2 == 0) ? 8'h5A : 8'hA5, 4'd8);
            chk("g4_valid", {263'd0, out_valid}, 264'd1);
            chk("g4_sym", {263'd0, new_sym}, 264'd1);
            chk("g4_word", lane_tx_enc, (c % 2 == 0) ? {w4(8'h5A), w4(8'hA5)} : {w4(8'hA5), w4(8'h5A)});
        end
        in_valid = 1'b0; enable = 1'b0;
        tick();
        chk("dis_valid", {263'd0, out_valid}, 264'd0);
        chk("dis_enc", lane_tx_enc, 264'd0);

        // Reset mid Gen3 block, then reserved speed
        enable = 1'b1; gen_speed = 2'd1;
        tick();
        for (int i = 0; i < 9; i++) send(i[7:0], i[7:0], 4'd8);
        rst = 1'b0;
        send(8'h09, 8'h09, 4'd8);
        rst = 1'b1; in_valid = 1'b0;
        chk("mrst_valid", {263'd0, out_valid}, 264'd0);
        chk("mrst_enc", lane_tx_enc, 264'd0);
        chk("mrst_sym", {263'd0, new_sym}, 264'd0);
        chk("mrst_serr", {263'd0, speed_err}, 264'd0);
        gen_speed = 2'd3;
        #1;
        chk("g3r_in_ready", {263'd0, in_ready}, 264'd0);
        tick();
        chk("g3r_serr", {263'd0, speed_err}, 264'd1);
        chk("g3r_valid", {263'd0, out_valid}, 264'd0);
        enable = 1'b0;
        tick();
        chk("serr_sticky_dis", {263'd0, speed_err}, 264'd1);
        enable = 1'b1; gen_speed = 2'd1;
        tick();
        for (int i = 0; i < 15; i++) send(8'h20 + i[7:0], 8'h30 + i[7:0], 4'd8);
        chk("post_not_early", {263'd0, out_valid}, 264'd0);
        send(8'h2F, 8'h3F, 4'd8);
        in_valid = 1'b0;
        chk("post_word", lane_tx_enc, {w3(8'h30, 1'b1), w3(8'h20, 1'b1)});
        chk("post_serr", {263'd0, speed_err}, 264'd1);
        rst = 1'b0;
        tick();
        chk("final_serr", {263'd0, speed_err}, 264'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
